// File: rtl/mux_2_4_arbiter.sv
// Round-robin arbiter that shares a registered WIDTH-bit output channel between
// requesters A and B, with a per-grant burst limit and a one-deep output register.
module mux_2_4_arbiter #(
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;          // 1 = B was served last
    logic [3:0]       count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             can_load;
    logic             burst_done;
    logic [WIDTH-1:0] mux_data;

    assign can_load   = !out_valid_q || out_ready;
    assign burst_done = (count_q + 4'd1) == BURST_L;
    assign mux_data   = sel_q ? data_b : data_a;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            count_q     <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req_a && req_b)
                    state_d = last_q ? GNT_A : GNT_B;
                else if (req_a)
                    state_d = GNT_A;
                else if (req_b)
                    state_d = GNT_B;
            end
            GNT_A: begin
                if (ack_a) begin
                    last_d = 1'b0;
                    if (burst_done) begin
                        count_d = 4'd0;
                        if (req_b)
                            state_d = GNT_B;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end else if (!req_a) begin
                    count_d = 4'd0;
                    state_d = req_b ? GNT_B : IDLE;
                end
            end
            GNT_B: begin
                if (ack_b) begin
                    last_d = 1'b1;
                    if (burst_done) begin
                        count_d = 4'd0;
                        if (req_a)
                            state_d = GNT_A;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end else if (!req_b) begin
                    count_d = 4'd0;
                    state_d = req_a ? GNT_A : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Select follows the grant and keeps its last value while idle
        sel_d = sel_q;
        if (state_d == GNT_A)
            sel_d = 1'b0;
        else if (state_d == GNT_B)
            sel_d = 1'b1;
    end

    // Output logic
    always_comb begin
        ack_a = !reset && (state_q == GNT_A) && req_a && can_load;
        ack_b = !reset && (state_q == GNT_B) && req_b && can_load;
    end

    // Output register: a load replaces any word being drained in the same cycle
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (ack_a || ack_b) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux_2_4_arbiter.sv
// Randomized self-checking bench for mux_2_4_arbiter against a cycle-level
// behavioural model of the grant/burst/output-register rules.
module tb_mux_2_4_arbiter;

    localparam int WIDTH = 4;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_a, req_b;
    logic [WIDTH-1:0] data_a, data_b;
    logic             ack_a, ack_b;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    int errors = 0;
    int checks = 0;

    // Model: grant owner 0 = none, 1 = A, 2 = B
    int               m_owner = 0;
    int               m_last  = 2;
    int               m_beats = 0;
    logic             m_sel   = 1'b0;
    logic             m_vld   = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_ack_a, m_ack_b;

    mux_2_4_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive after negedge, check acks, advance model at posedge,
    // check registered outputs at the following negedge.
    task automatic step(input logic rst, input logic ra, input logic [WIDTH-1:0] da,
                        input logic rb, input logic [WIDTH-1:0] db, input logic rdy);
        bit ra_i, rb_i;
        reset = rst; req_a = ra; data_a = da; req_b = rb; data_b = db; out_ready = rdy;
        #1;
        m_ack_a = !rst && m_owner == 1 && ra && (!m_vld || rdy);
        m_ack_b = !rst && m_owner == 2 && rb && (!m_vld || rdy);
        check("ack_a", ack_a, m_ack_a);
        check("ack_b", ack_b, m_ack_b);
        @(posedge clk);
        ra_i = ra; rb_i = rb;
        if (rst) begin
            m_owner = 0; m_last = 2; m_beats = 0;
            m_sel = 1'b0; m_vld = 1'b0; m_data = '0;
        end else begin
            if (m_ack_a || m_ack_b) begin
                m_data = m_ack_a ? da : db;
                m_vld  = 1'b1;
                m_last = m_owner;
                m_beats++;
                $display("txn: side=%s data=%h beat=%0d", m_ack_a ? "A" : "B", m_data, m_beats);
                if (m_beats == BURST) begin
                    m_beats = 0;
                    if (m_owner == 1 && rb_i) m_owner = 2;
                    else if (m_owner == 2 && ra_i) m_owner = 1;
                end
            end else begin
                if (m_vld && rdy) m_vld = 1'b0;
                if (m_owner == 0) begin
                    if (ra_i && rb_i) m_owner = (m_last == 2) ? 1 : 2;
                    else if (ra_i) m_owner = 1;
                    else if (rb_i) m_owner = 2;
                end else if ((m_owner == 1 && !ra_i) || (m_owner == 2 && !rb_i)) begin
                    m_beats = 0;
                    if (m_owner == 1) m_owner = rb_i ? 2 : 0;
                    else m_owner = ra_i ? 1 : 0;
                end
            end
            if (m_owner == 1) m_sel = 1'b0;
            else if (m_owner == 2) m_sel = 1'b1;
        end
        @(negedge clk);
        check("sel", sel, m_sel);
        check("out_valid", out_valid, m_vld);
        check("out_data", out_data, m_data);
    endtask

    initial begin
        logic             ra, rb, rdy, rst;
        logic [WIDTH-1:0] da, db;
        ra = 1'b0; rb = 1'b0; da = '0; db = '0;
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles with both requesting
        step(1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
        step(1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
        check("rst_sel", sel, 1'b0);
        check("rst_data", out_data, 4'h0);

        // Contention with full throughput
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Single requester, then backpressure
        step(1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0);
        check("stall_data", out_data, 4'h3);
        step(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
        check("resume_data", out_data, 4'h7);

        // Early release by A while B waits
        step(1'b0, 1'b1, 4'h1, 1'b1, 4'h9, 1'b1);
        step(1'b0, 1'b0, 4'h1, 1'b1, 4'h9, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0, 1'b1, 4'(i + 8), 1'b1);

        // Mid-burst reset during GNT_B with a word held
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'hA, 1'b0);
        step(1'b1, 1'b1, 4'h2, 1'b1, 4'hB, 1'b0);
        check("mrst_valid", out_valid, 1'b0);
        step(1'b0, 1'b1, 4'h2, 1'b1, 4'hB, 1'b1);
        check("mrst_tie_sel", sel, 1'b0);

        // Randomized traffic; an unacknowledged word is held stable
        ra = 1'b0; rb = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (!(ra && !m_ack_a) || rst) begin
                if (!(ra && !m_ack_a)) begin
                    ra = ($urandom_range(0, 3) != 0);
                    da = WIDTH'($urandom);
                end
            end
            if (!(rb && !m_ack_b)) begin
                rb = ($urandom_range(0, 3) != 0);
                db = WIDTH'($urandom);
            end
            rdy = ($urandom_range(0, 3) != 0);
            step(rst, ra, da, rb, db, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
